// File: rtl/csb_master_initiator_if.sv
// csb_master_initiator_if: command, CSB request/response and completion signals of the CSB initiator
interface csb_master_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [21:0] cmd_addr;
    logic [31:0] cmd_wdat;
    logic        cmd_write;
    logic        cmd_nposted;
    logic [3:0]  cmd_wrbe;
    logic        csb_req_pvld;
    logic        csb_req_prdy;
    logic [62:0] csb_req_pd;
    logic        csb_resp_valid;
    logic [33:0] csb_resp_pd;
    logic        done_valid;
    logic [31:0] done_rdat;
    logic        done_error;
    logic        done_timeout;
    logic        stray_resp;

    modport master (
        input  cmd_valid, cmd_addr, cmd_wdat, cmd_write, cmd_nposted, cmd_wrbe,
        input  csb_req_prdy, csb_resp_valid, csb_resp_pd,
        output cmd_ready, csb_req_pvld, csb_req_pd,
        output done_valid, done_rdat, done_error, done_timeout, stray_resp
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_wdat, cmd_write, cmd_nposted, cmd_wrbe,
        output csb_req_prdy, csb_resp_valid, csb_resp_pd,
        input  cmd_ready, csb_req_pvld, csb_req_pd,
        input  done_valid, done_rdat, done_error, done_timeout, stray_resp
    );
endinterface

// File: rtl/csb_master_initiator.sv
// csb_master_initiator: single-outstanding NVDLA CSB register-bus initiator with response timeout
module csb_master_initiator #(
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input logic                     nvdla_core_clk,
    input logic                     nvdla_core_rstn,
    csb_master_initiator_if.master  bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    state_t          state;
    logic [TO_W-1:0] cnt;
    logic            wr;
    logic            posted;
    logic            resp_err;

    assign bus.cmd_ready = (state == IDLE);
    assign wr            = bus.csb_req_pd[54];
    assign posted        = wr && !bus.csb_req_pd[55];
    assign resp_err      = bus.csb_resp_pd[32] || (bus.csb_resp_pd[33] != wr);

    // Transaction FSM: latch command, hold request until accepted, await response or timeout, pulse completion
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.csb_req_pvld <= 1'b0;
            bus.csb_req_pd   <= '0;
            bus.done_valid   <= 1'b0;
            bus.done_rdat    <= '0;
            bus.done_error   <= 1'b0;
            bus.done_timeout <= 1'b0;
            bus.stray_resp   <= 1'b0;
        end else begin
            bus.done_valid <= 1'b0;
            if (bus.csb_resp_valid && state != WAIT)
                bus.stray_resp <= 1'b1;
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    bus.csb_req_pd <= {2'b00,
                                       bus.cmd_write ? bus.cmd_wrbe : 4'h0,
                                       1'b0,
                                       bus.cmd_write ? bus.cmd_nposted : 1'b1,
                                       bus.cmd_write,
                                       bus.cmd_write ? bus.cmd_wdat : 32'h0,
                                       bus.cmd_addr};
                    bus.csb_req_pvld <= 1'b1;
                    state            <= REQ;
                end
                REQ: if (bus.csb_req_prdy) begin
                    bus.csb_req_pvld <= 1'b0;
                    cnt              <= '0;
                    if (posted) begin
                        bus.done_valid   <= 1'b1;
                        bus.done_rdat    <= '0;
                        bus.done_error   <= 1'b0;
                        bus.done_timeout <= 1'b0;
                        state            <= DONE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (bus.csb_resp_valid) begin
                        bus.done_valid   <= 1'b1;
                        bus.done_rdat    <= wr ? 32'h0 : bus.csb_resp_pd[31:0];
                        bus.done_error   <= resp_err;
                        bus.done_timeout <= 1'b0;
                        state            <= DONE;
                    end else if (TIMEOUT != 0 && cnt == LAST) begin
                        bus.done_valid   <= 1'b1;
                        bus.done_rdat    <= '0;
                        bus.done_error   <= 1'b1;
                        bus.done_timeout <= 1'b1;
                        state            <= DONE;
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule
